mem_responder: RTL and testbench



---
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder.sv | 118 +++++++++++
 tb/tb_mem_responder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the allocator, the responder and the host link.
// Carries: request (rdy_in, mem_a_in, mem_d_in, mem_wr_in), read data (mem_d_out),
// tx byte link (tx_*), rx byte load (rx_*) and status (io_full_out, overflow_out, halt_out).
interface mem_responder_if;
  logic        rdy_in;
  logic [31:0] mem_a_in;
  logic [7:0]  mem_d_in;
  logic        mem_wr_in;
  logic [7:0]  mem_d_out;
  logic        io_full_out;
  logic        overflow_out;
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        halt_out;

  // Responder side.
  modport slave (
    input  rdy_in, mem_a_in, mem_d_in, mem_wr_in, tx_ready_in, rx_data_in, rx_valid_in,
    output mem_d_out, io_full_out, overflow_out, tx_data_out, tx_valid_out, halt_out
  );

  // Allocator / host side.
  modport master (
    output rdy_in, mem_a_in, mem_d_in, mem_wr_in, tx_ready_in, rx_data_in, rx_valid_in,
    input  mem_d_out, io_full_out, overflow_out, tx_data_out, tx_valid_out, halt_out
  );
endinterface

// File: rtl/mem_responder.sv
// Byte RAM + MMIO responder (tx FIFO at 0x30000 write, rx buffer at 0x30000 read, halt/status at 0x30004).
// Latency: read data registered, valid one cycle after the request edge; tx head is combinational from FIFO state.
// Backpressure: rdy_in low stalls all requests; io_full_out warns one entry early, pushes to a full FIFO are dropped (sticky overflow).
// Ports: clk_in, rst_in (sync, active-high), bus (mem_responder_if.slave).
module mem_responder #(
  parameter int RAM_AW     = 17,
  parameter int FIFO_DEPTH = 8
) (
  input logic            clk_in,
  input logic            rst_in,
  mem_responder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] NEAR_FULL_C = CW'(FIFO_DEPTH - 1);

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic              rx_full;
  logic [7:0]        rx_dat;
  logic              overflow;
  logic              halt;
  logic [7:0]        rd_dat;

  logic [RAM_AW-1:0] ram_addr;
  logic [15:0]       io_off;
  logic              io_hit;
  logic              ram_hit;
  logic              io_data_sel;
  logic              io_ctrl_sel;
  logic              fifo_full;
  logic              io_full;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              rx_rd;
  logic              unused_addr;

  assign ram_addr    = bus.mem_a_in[RAM_AW-1:0];
  assign io_off      = bus.mem_a_in[15:0];
  assign io_hit      = bus.rdy_in && (bus.mem_a_in[17:16] == 2'b11);
  assign ram_hit     = bus.rdy_in && (bus.mem_a_in[17:16] != 2'b11);
  assign io_data_sel = io_hit && (io_off == 16'h0000);
  assign io_ctrl_sel = io_hit && (io_off == 16'h0004);
  // Address bits above the decode field never participate.
  assign unused_addr = ^bus.mem_a_in[31:18];

  assign fifo_full = (count == DEPTH_C);
  assign io_full   = (count >= NEAR_FULL_C);
  assign push_req  = io_data_sel && bus.mem_wr_in;
  // A full FIFO drops the push even if a pop frees a slot in the same cycle.
  assign push      = push_req && !fifo_full;
  assign pop       = (count != '0) && bus.tx_ready_in;
  assign rx_rd     = io_data_sel && !bus.mem_wr_in;

  // RAM array has no reset; contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (!rst_in && ram_hit && bus.mem_wr_in) begin
      ram[ram_addr] <= bus.mem_d_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      fifo_mem[tail] <= bus.mem_d_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_dat   <= 8'h00;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      halt     <= 1'b0;
      rx_full  <= 1'b0;
      rx_dat   <= 8'h00;
    end else begin
      // Read data register holds whenever rdy_in is low.
      if (ram_hit) begin
        rd_dat <= bus.mem_wr_in ? 8'h00 : ram[ram_addr];
      end else if (io_hit) begin
        if (bus.mem_wr_in)     rd_dat <= 8'h00;
        else if (io_data_sel)  rd_dat <= rx_full ? rx_dat : 8'h00;
        else if (io_ctrl_sel)  rd_dat <= {7'b0, io_full};
        else                   rd_dat <= 8'h00;
      end

      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (push_req && fifo_full)              overflow <= 1'b1;
      if (io_ctrl_sel && bus.mem_wr_in)       halt     <= 1'b1;

      // A new rx byte wins over the read-clear; the read itself saw the old state.
      if (bus.rx_valid_in) begin
        rx_dat  <= bus.rx_data_in;
        rx_full <= 1'b1;
      end else if (rx_rd) begin
        rx_full <= 1'b0;
      end
    end
  end

  assign bus.mem_d_out    = rd_dat;
  assign bus.io_full_out  = io_full;
  assign bus.overflow_out = overflow;
  assign bus.tx_data_out  = fifo_mem[head];
  assign bus.tx_valid_out = (count != '0);
  assign bus.halt_out     = halt;
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic clk;
  logic rst;

  mem_responder_if bus();

  mem_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [7:0] ram_m [int unsigned];
  logic [7:0] q[$];
  logic       ovf_m, halt_m, rx_full_m;
  logic [7:0] rx_m, dout_m;
  bit         dout_known;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One clock: drive inputs, advance the model at the edge, compare just after it.
  task automatic step(input logic r, input logic rdy, input logic [31:0] a, input logic [7:0] d,
                      input logic wr, input logic txr, input logic [7:0] rxd, input logic rxv);
    bit do_pop, do_push;
    int pre_size;
    int unsigned ad;
    rst = r;
    bus.rdy_in = rdy; bus.mem_a_in = a; bus.mem_d_in = d; bus.mem_wr_in = wr;
    bus.tx_ready_in = txr; bus.rx_data_in = rxd; bus.rx_valid_in = rxv;
    @(posedge clk);
    if (r) begin
      q.delete(); ovf_m = 0; halt_m = 0; rx_full_m = 0; dout_m = 8'h00; dout_known = 1;
    end else begin
      pre_size = q.size();
      do_pop   = (pre_size != 0) && txr;
      do_push  = 0;
      if (rdy) begin
        if (a[17:16] == 2'b11) begin
          dout_known = 1;
          if (wr) begin
            dout_m = 8'h00;
            if (a[15:0] == 16'h0000) begin
              if (pre_size == 8) ovf_m = 1; else do_push = 1;
            end else if (a[15:0] == 16'h0004) halt_m = 1;
          end else if (a[15:0] == 16'h0000) begin
            dout_m = rx_full_m ? rx_m : 8'h00;
            rx_full_m = 0;
          end else if (a[15:0] == 16'h0004) dout_m = (pre_size >= 7) ? 8'h01 : 8'h00;
          else dout_m = 8'h00;
        end else begin
          ad = a[16:0];
          if (wr) begin ram_m[ad] = d; dout_m = 8'h00; dout_known = 1; end
          else if (ram_m.exists(ad)) begin dout_m = ram_m[ad]; dout_known = 1; end
          else dout_known = 0;
        end
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (rxv) begin rx_m = rxd; rx_full_m = 1; end
    end
    #1;
    if (dout_known) chk("mem_d_out", bus.mem_d_out, dout_m);
    chk("tx_valid", {7'b0, bus.tx_valid_out}, (q.size() != 0) ? 8'h01 : 8'h00);
    if (q.size() != 0) chk("tx_data", bus.tx_data_out, q[0]);
    chk("io_full", {7'b0, bus.io_full_out}, (q.size() >= 7) ? 8'h01 : 8'h00);
    chk("overflow", {7'b0, bus.overflow_out}, {7'b0, ovf_m});
    chk("halt", {7'b0, bus.halt_out}, {7'b0, halt_m});
  endtask

  task automatic idle(input logic txr);
    step(0, 0, 32'h0, 8'h00, 0, txr, 8'h00, 0);
  endtask

  initial begin
    logic [31:0] a;
    int kind;
    dout_known = 0; ovf_m = 0; halt_m = 0; rx_full_m = 0; rx_m = 8'h00; dout_m = 8'h00;
    rst = 1;
    bus.rdy_in = 0; bus.mem_a_in = 0; bus.mem_d_in = 0; bus.mem_wr_in = 0;
    bus.tx_ready_in = 0; bus.rx_data_in = 0; bus.rx_valid_in = 0;

    // Reset state
    step(1, 0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    step(1, 0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    chk("rst_dout", bus.mem_d_out, 8'h00);
    chk("rst_txv", {7'b0, bus.tx_valid_out}, 8'h00);
    chk("rst_ovf", {7'b0, bus.overflow_out}, 8'h00);
    chk("rst_halt", {7'b0, bus.halt_out}, 8'h00);

    // RAM write then back-to-back reads
    step(0, 1, 32'h00010, 8'hA5, 1, 0, 8'h00, 0);
    step(0, 1, 32'h00011, 8'h5B, 1, 0, 8'h00, 0);
    step(0, 1, 32'h00010, 8'h00, 0, 0, 8'h00, 0);
    chk("rd_first", bus.mem_d_out, 8'hA5);
    step(0, 1, 32'h00011, 8'h00, 0, 0, 8'h00, 0);
    chk("rd_second", bus.mem_d_out, 8'h5B);

    // rdy_in low holds read data
    step(0, 1, 32'h00020, 8'h3C, 1, 0, 8'h00, 0);
    step(0, 1, 32'h00010, 8'h00, 0, 0, 8'h00, 0);
    step(0, 0, 32'h00020, 8'h00, 0, 0, 8'h00, 0);
    chk("rdy_hold", bus.mem_d_out, 8'hA5);
    step(0, 1, 32'h00020, 8'h00, 0, 0, 8'h00, 0);
    chk("rdy_resume", bus.mem_d_out, 8'h3C);

    // Fill FIFO, overflow, drain in order
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 32'h30000, 8'(8'h41 + i), 1, 0, 8'h00, 0);
      if (i == 5) chk("io_full_at6", {7'b0, bus.io_full_out}, 8'h00);
      if (i == 6) chk("io_full_at7", {7'b0, bus.io_full_out}, 8'h01);
    end
    step(0, 1, 32'h30000, 8'h49, 1, 0, 8'h00, 0);
    chk("ovf_set", {7'b0, bus.overflow_out}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", bus.tx_data_out, 8'(8'h41 + i));
      idle(1);
    end
    chk("drain_empty", {7'b0, bus.tx_valid_out}, 8'h00);

    // Push+pop on full FIFO, then push+pop across pointer wrap
    step(1, 0, 32'h0, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h30000, 8'(8'h61 + i), 1, 0, 8'h00, 0);
    step(0, 1, 32'h30000, 8'h70, 1, 1, 8'h00, 0);
    chk("full_pp_ovf", {7'b0, bus.overflow_out}, 8'h01);
    chk("full_pp_head", bus.tx_data_out, 8'h62);
    for (int i = 0; i < 3; i++) idle(1);
    for (int i = 0; i < 6; i++) step(0, 1, 32'h30000, 8'(8'h80 + i), 1, 1, 8'h00, 0);
    for (int i = 0; i < 5; i++) idle(1);

    // rx buffer
    step(0, 0, 32'h0, 8'h00, 0, 0, 8'h55, 1);
    step(0, 1, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("rx_read", bus.mem_d_out, 8'h55);
    step(0, 1, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("rx_empty", bus.mem_d_out, 8'h00);
    step(0, 1, 32'h30000, 8'h00, 0, 0, 8'h66, 1);
    chk("rx_coincident", bus.mem_d_out, 8'h00);
    step(0, 1, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("rx_after", bus.mem_d_out, 8'h66);
    step(0, 1, 32'h30004, 8'h00, 0, 0, 8'h00, 0);

    // Halt, then reset mid-operation
    step(0, 1, 32'h30004, 8'hFF, 1, 0, 8'h00, 0);
    chk("halt_set", {7'b0, bus.halt_out}, 8'h01);
    idle(0); idle(0);
    chk("halt_sticky", {7'b0, bus.halt_out}, 8'h01);
    step(0, 1, 32'h30000, 8'h11, 1, 0, 8'h00, 0);
    step(0, 1, 32'h30000, 8'h22, 1, 0, 8'h77, 1);
    step(1, 1, 32'h00010, 8'h00, 0, 0, 8'h00, 0);
    chk("rst_mid_dout", bus.mem_d_out, 8'h00);
    chk("rst_mid_halt", {7'b0, bus.halt_out}, 8'h00);
    chk("rst_mid_txv", {7'b0, bus.tx_valid_out}, 8'h00);
    step(0, 1, 32'h30000, 8'h00, 0, 0, 8'h00, 0);
    chk("rst_mid_rx", bus.mem_d_out, 8'h00);

    // Seed a small RAM region in both halves of the address space
    for (int i = 0; i < 32; i++) begin
      step(0, 1, 32'(i), 8'(i * 7 + 3), 1, 0, 8'h00, 0);
      step(0, 1, 32'h10000 + 32'(i), 8'(i * 13 + 1), 1, 0, 8'h00, 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom & 32'hFFFC_0000;
      if (kind <= 3)      a = a | ($urandom_range(0, 1) << 16) | $urandom_range(0, 31);
      else if (kind <= 6) a = a | 32'h30000;
      else if (kind == 7) a = a | 32'h30004;
      else if (kind == 8) begin
        a = a | 32'h30000 | $urandom_range(1, 16'hFFFF);
        if (a[15:0] == 16'h0004) a[3] = 1'b1;
      end else a = a | 32'h30004;
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0), a, 8'($urandom),
           (kind == 7) ? ($urandom_range(0, 9) == 0) : 1'($urandom), 1'($urandom_range(0, 2) == 0),
           8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
